// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard frame receiver producing the 11-bit ps2_key event bus {toggle, pressed, extended, code}.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated make events for the key already held.
module ps2_key_encoder #(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 49152
) (
   input  logic        clk_sys,
   input  logic        I_RESETn,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);

   localparam int FW = (FILT > 1) ? $clog2(FILT + 1) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_fclk;
   logic [FW-1:0] r_fcnt;
   logic [TW-1:0] r_tcnt;
   state_t        r_state;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic          r_acc;
   logic [7:0]    r_byte;
   logic          r_err;
   logic          r_busy;
   logic          r_ext, r_brk;
   logic [2:0]    r_skip;
   logic [10:0]   r_key;

   logic          w_chg, w_fall, w_tout;
   logic [10:0]   w_event;

   // A filtered edge is the cycle the synchronised level has differed for FILT cycles.
   assign w_chg   = (r_clk_s2 != r_fclk) && (r_fcnt == FW'(FILT - 1));
   assign w_fall  = w_chg && r_fclk;
   assign w_tout  = (r_tcnt == TW'(TIMEOUT - 1)) && !w_chg;
   assign w_event = {~r_key[10], ~r_brk, r_ext, r_byte};

   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
         r_fclk   <= 1'b1;
         r_fcnt   <= '0;
         r_tcnt   <= '0;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
         if (r_clk_s2 == r_fclk) begin
            r_fcnt <= '0;
         end else if (w_chg) begin
            r_fclk <= r_clk_s2;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
         if (w_chg)
            r_tcnt <= '0;
         else if (r_tcnt != TW'(TIMEOUT))
            r_tcnt <= r_tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         r_state  <= S_IDLE;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_acc    <= 1'b0;
         r_byte   <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         r_acc <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall && !r_dat_s2) begin
                  r_state  <= S_DATA;
                  r_busy   <= 1'b1;
                  r_bitcnt <= '0;
               end
            end
            S_DATA: begin
               if (w_tout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else if (w_fall) begin
                  r_shift  <= {r_dat_s2, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 3'd7)
                     r_state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (w_tout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else if (w_fall) begin
                  r_par   <= r_dat_s2;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_tout) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
               end else if (w_fall) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  if (r_dat_s2 && (^{r_shift, r_par})) begin
                     r_acc  <= 1'b1;
                     r_byte <= r_shift;
                  end else begin
                     r_err  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       r_lm_valid, r_lm_ext;
   logic [7:0] r_lm_code;
   logic       w_repeat;

   assign w_repeat = r_lm_valid && (r_lm_ext == r_ext) && (r_lm_code == r_byte);
`endif

   // Skip counting takes priority so the bytes inside a Pause sequence (including its E1) are swallowed.
   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         r_key  <= '0;
         r_ext  <= 1'b0;
         r_brk  <= 1'b0;
         r_skip <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         r_lm_valid <= 1'b0;
         r_lm_ext   <= 1'b0;
         r_lm_code  <= '0;
`endif
      end else if (r_err) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_acc) begin
         if (r_skip != 3'd0) begin
            r_skip <= r_skip - 1'b1;
         end else if (r_byte == 8'hE0) begin
            r_ext <= 1'b1;
         end else if (r_byte == 8'hF0) begin
            r_brk <= 1'b1;
         end else if (r_byte == 8'hE1) begin
            r_skip <= 3'd7;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (r_brk) begin
               r_key      <= w_event;
               r_lm_valid <= 1'b0;
            end else if (!w_repeat) begin
               r_key      <= w_event;
               r_lm_valid <= 1'b1;
               r_lm_ext   <= r_ext;
               r_lm_code  <= r_byte;
            end
`else
            r_key <= w_event;
`endif
         end
      end
   end

   assign ps2_key   = r_key;
   assign frame_err = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed table-driven bench for ps2_key_encoder, plus hand sequences for latency, timeout and reset.
module tb_ps2_key_encoder;

   localparam int FILT    = 8;
   localparam int TIMEOUT = 2000;
   localparam int HALF    = 20;

   logic        clk_sys;
   logic        rst_n;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        frame_err;
   logic        busy;

   int checks;
   int errors;
   int n_err_pulse;

   typedef struct {
      logic [7:0]  data;
      logic        bad_par;
      logic        bad_stop;
      logic [10:0] exp_key;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   ps2_key_encoder #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys  (clk_sys),
      .I_RESETn (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .ps2_key  (ps2_key),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (frame_err === 1'b1)
         n_err_pulse = n_err_pulse + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_bits(input logic [10:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = b[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic par;
      par = (~^d) ^ bad_par;
      send_bits({~bad_stop, par, d, 1'b0}, 11);
   endtask

   task automatic add(input logic [7:0] d, input logic bp, input logic bs,
                      input logic [10:0] k, input logic e);
      vec_t v;
      v.data = d; v.bad_par = bp; v.bad_stop = bs; v.exp_key = k; v.exp_err = e;
      vecs.push_back(v);
   endtask

   initial begin
      int e0;
      int n;
      logic seen;
      checks      = 0;
      errors      = 0;
      n_err_pulse = 0;
      rst_n       = 1'b0;
      ps2_clk     = 1'b1;
      ps2_data    = 1'b1;

      add(8'h1C, 0, 0, 11'h61C, 0);
      add(8'hF0, 0, 0, 11'h61C, 0);
      add(8'h1C, 0, 0, 11'h01C, 0);
      add(8'hE0, 0, 0, 11'h01C, 0);
      add(8'h75, 0, 0, 11'h775, 0);
      add(8'hE0, 0, 0, 11'h775, 0);
      add(8'hF0, 0, 0, 11'h775, 0);
      add(8'h75, 0, 0, 11'h175, 0);
      add(8'hF0, 0, 0, 11'h175, 0);
      add(8'hE0, 0, 0, 11'h175, 0);
      add(8'h75, 0, 0, 11'h575, 0);
      add(8'h29, 1, 0, 11'h575, 1);
      add(8'h29, 0, 0, 11'h229, 0);
      add(8'h29, 0, 1, 11'h229, 1);
      add(8'hE0, 0, 0, 11'h229, 0);
      add(8'h29, 1, 0, 11'h229, 1);
      add(8'h4D, 0, 0, 11'h64D, 0);
      add(8'hE1, 0, 0, 11'h64D, 0);
      add(8'h14, 0, 0, 11'h64D, 0);
      add(8'h77, 0, 0, 11'h64D, 0);
      add(8'hE1, 0, 0, 11'h64D, 0);
      add(8'hF0, 0, 0, 11'h64D, 0);
      add(8'h14, 0, 0, 11'h64D, 0);
      add(8'hF0, 0, 0, 11'h64D, 0);
      add(8'h77, 0, 0, 11'h64D, 0);
      add(8'h1C, 0, 0, 11'h21C, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
      add(8'h1C, 0, 0, 11'h21C, 0);
      add(8'h1C, 0, 0, 11'h21C, 0);
`else
      add(8'h1C, 0, 0, 11'h61C, 0);
      add(8'h1C, 0, 0, 11'h21C, 0);
`endif
      add(8'hF0, 0, 0, 11'h21C, 0);
      add(8'h1C, 0, 0, 11'h41C, 0);
      add(8'h1C, 0, 0, 11'h21C, 0);

      wait_cyc(3);
      chk("reset_key", 32'(ps2_key), 32'h000);
      chk("reset_err", 32'(frame_err), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      wait_cyc(5);

      // Short low glitch on ps2_clk with data low must not start a frame.
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cyc(4);
      ps2_clk  = 1'b1;
      wait_cyc(FILT + 5);
      chk("glitch_busy", 32'(busy), 32'h0);
      ps2_data = 1'b1;
      wait_cyc(HALF);

      for (int i = 0; i < vecs.size(); i++) begin
         e0 = n_err_pulse;
         send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
         wait_cyc(HALF);
         chk($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
         chk($sformatf("vec%0d_err", i), 32'(n_err_pulse - e0), 32'(vecs[i].exp_err));
      end
      chk("after_table_busy", 32'(busy), 32'h0);

      // Latency: key must change on the (FILT+3)th posedge after the raw stop-bit fall.
      send_bits({1'b0, ~^8'h5A, 8'h5A, 1'b0}, 10);
      ps2_data = 1'b1;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      for (int k = 1; k <= FILT + 3; k++) begin
         @(posedge clk_sys);
         #1;
         if (k == FILT + 2) chk("lat_before", 32'(ps2_key), 32'h21C);
         if (k == FILT + 3) chk("lat_after", 32'(ps2_key), 32'h65A);
      end
      @(negedge clk_sys);
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF);

      // Timeout after start + 4 data bits.
      e0 = n_err_pulse;
      send_bits({2'b00, 8'h29, 1'b0}, 5);
      chk("to_busy_mid", 32'(busy), 32'h1);
      seen = 1'b0;
      n = 0;
      for (int k = 1; k <= TIMEOUT + FILT + 50; k++) begin
         @(posedge clk_sys);
         #1;
         if (frame_err === 1'b1) begin
            seen = 1'b1;
            n = k;
            break;
         end
      end
      chk("to_seen", 32'(seen), 32'h1);
      chk("to_window", 32'((n >= TIMEOUT) && (n <= TIMEOUT + FILT + 4)), 32'h1);
      @(posedge clk_sys);
      #1;
      chk("to_pulse_one_cycle", 32'(frame_err), 32'h0);
      chk("to_busy_drop", 32'(busy), 32'h0);
      chk("to_key_hold", 32'(ps2_key), 32'h65A);
      @(negedge clk_sys);
      wait_cyc(HALF);
      send_frame(8'h29, 0, 0);
      wait_cyc(HALF);
      chk("to_next_key", 32'(ps2_key), 32'h229);
      chk("to_err_count", 32'(n_err_pulse - e0), 32'h1);

      // Back-to-back frames with only one bit time between them.
      e0 = n_err_pulse;
      send_frame(8'hF0, 0, 0);
      send_frame(8'h29, 0, 0);
      wait_cyc(HALF);
      chk("b2b_key", 32'(ps2_key), 32'h429);
      chk("b2b_err", 32'(n_err_pulse - e0), 32'h0);

      // Reset asserted mid-frame.
      send_bits({3'b000, 8'h1C, 1'b0}, 4);
      rst_n = 1'b0;
      wait_cyc(2);
      chk("mrst_key", 32'(ps2_key), 32'h000);
      chk("mrst_busy", 32'(busy), 32'h0);
      e0 = n_err_pulse;
      ps2_data = 1'b1;
      rst_n = 1'b1;
      wait_cyc(TIMEOUT + 100);
      chk("mrst_no_err", 32'(n_err_pulse - e0), 32'h0);
      chk("mrst_busy_after", 32'(busy), 32'h0);
      send_frame(8'h1C, 0, 0);
      wait_cyc(HALF);
      chk("mrst_next_key", 32'(ps2_key), 32'h61C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
